// File: rtl/integrate_dump.sv
// integrate_dump: integrate-and-dump accumulator for signed samples.
// Samples are sign-extended and summed with saturation until a dump strobe
// closes the interval; the totals are then held for a valid/ready consumer.
//
// Ports:
//   clk        - clock, rising edge
//   reset_n    - asynchronous active-low reset
//   in_valid   - in_value carries a sample this cycle
//   in_value   - signed two's-complement sample, IN_WIDTH bits
//   dump       - one-cycle strobe closing the current interval
//   out_ready  - consumer accepts the held result
//   out_valid  - a result is held for the consumer
//   out_value  - signed integrated sum, ACC_WIDTH bits
//   out_count  - samples in the interval (saturating), CNT_WIDTH bits
//   out_sat    - the interval clamped at least once
//   overrun    - one-cycle pulse: an unconsumed result was overwritten
//
// Output state machine:
//   state | meaning
//   EMPTY | no result held, out_valid=0
//   FULL  | result held, out_valid=1, waiting for handshake
module integrate_dump #(
  parameter int IN_WIDTH  = 4,
  parameter int ACC_WIDTH = 16,
  parameter int CNT_WIDTH = 14
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 in_valid,
  input  logic [IN_WIDTH-1:0]  in_value,
  input  logic                 dump,
  input  logic                 out_ready,
  output logic                 out_valid,
  output logic [ACC_WIDTH-1:0] out_value,
  output logic [CNT_WIDTH-1:0] out_count,
  output logic                 out_sat,
  output logic                 overrun
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  state_t               state;
  logic [ACC_WIDTH-1:0] acc;
  logic [CNT_WIDTH-1:0] cnt;
  logic                 sat_flag;

  logic [ACC_WIDTH-1:0] sample_ext;
  logic [ACC_WIDTH:0]   sum_wide;
  logic [ACC_WIDTH-1:0] acc_sum;
  logic [ACC_WIDTH-1:0] acc_next;
  logic [CNT_WIDTH-1:0] cnt_next;
  logic                 clamp;
  logic                 sat_next;

  // Interval totals including the current-cycle sample; these feed both the
  // running registers and, on dump, the result registers.
  always_comb begin
    sample_ext = {{(ACC_WIDTH-IN_WIDTH){in_value[IN_WIDTH-1]}}, in_value};
    // One guard bit: overflow shows up as the top two bits disagreeing.
    sum_wide   = {acc[ACC_WIDTH-1], acc} + {sample_ext[ACC_WIDTH-1], sample_ext};
    clamp      = sum_wide[ACC_WIDTH] ^ sum_wide[ACC_WIDTH-1];
    if (!clamp)
      acc_sum = sum_wide[ACC_WIDTH-1:0];
    else if (sum_wide[ACC_WIDTH])
      acc_sum = ACC_MIN;
    else
      acc_sum = ACC_MAX;

    acc_next = in_valid ? acc_sum : acc;
    sat_next = sat_flag | (in_valid & clamp);
    cnt_next = cnt;
    if (in_valid && !(&cnt))
      cnt_next = cnt + CNT_ONE;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc      <= '0;
      cnt      <= '0;
      sat_flag <= 1'b0;
    end else if (dump) begin
      acc      <= '0;
      cnt      <= '0;
      sat_flag <= 1'b0;
    end else begin
      acc      <= acc_next;
      cnt      <= cnt_next;
      sat_flag <= sat_next;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= EMPTY;
      out_valid <= 1'b0;
      out_value <= '0;
      out_count <= '0;
      out_sat   <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (dump) begin
        out_value <= acc_next;
        out_count <= cnt_next;
        out_sat   <= sat_next;
      end
      case (state)
        EMPTY: begin
          if (dump) begin
            state     <= FULL;
            out_valid <= 1'b1;
          end
        end
        FULL: begin
          if (dump) begin
            // Reloading while the consumer takes the old result is a normal
            // back-to-back transfer; without ready the old result is lost.
            overrun <= ~out_ready;
          end else if (out_ready) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state     <= EMPTY;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_integrate_dump.sv
// Bench for integrate_dump (IN_WIDTH=4, ACC_WIDTH=8, CNT_WIDTH=6).
// Stimulus pushes hand-computed results into a queue; the monitor pops one
// per handshake and also compares out_valid/overrun with a small model.
module tb_integrate_dump;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [3:0] in_value = 4'h0;
  logic       dump = 1'b0;
  logic       out_ready = 1'b0;
  logic       out_valid;
  logic [7:0] out_value;
  logic [5:0] out_count;
  logic       out_sat;
  logic       overrun;

  typedef struct packed {
    logic [7:0] v;
    logic [5:0] c;
    logic       s;
  } res_t;

  res_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  logic m_full;
  logic m_ovr;

  integrate_dump #(.IN_WIDTH(4), .ACC_WIDTH(8), .CNT_WIDTH(6)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_value(in_value),
    .dump(dump), .out_ready(out_ready), .out_valid(out_valid),
    .out_value(out_value), .out_count(out_count), .out_sat(out_sat),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Handshake model: held/empty and the overrun pulse, from the bench's own inputs.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_full <= 1'b0;
      m_ovr  <= 1'b0;
    end else begin
      m_ovr <= dump && m_full && !out_ready;
      if (dump)
        m_full <= 1'b1;
      else if (m_full && out_ready)
        m_full <= 1'b0;
    end
  end

  // Monitor samples mid-cycle, away from the rising edge.
  always @(negedge clk) begin
    if (reset_n) begin
      check("out_valid", {31'b0, out_valid}, {31'b0, m_full});
      check("overrun", {31'b0, overrun}, {31'b0, m_ovr});
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_result", 32'd1, 32'd0);
        end else begin
          res_t e;
          e = exp_q.pop_front();
          check("out_value", {24'b0, out_value}, {24'b0, e.v});
          check("out_count", {26'b0, out_count}, {26'b0, e.c});
          check("out_sat", {31'b0, out_sat}, {31'b0, e.s});
        end
      end
    end
  end

  task automatic tick(input logic v, input logic [3:0] val, input logic d);
    in_valid = v;
    in_value = val;
    dump     = d;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    dump     = 1'b0;
  endtask

  task automatic send(input int n, input logic [3:0] val);
    for (int i = 0; i < n; i++) tick(1'b1, val, 1'b0);
  endtask

  task automatic do_dump(input logic v, input logic [3:0] val,
                         input logic [7:0] ev, input logic [5:0] ec, input logic es);
    res_t e;
    // A held result that is not being taken this cycle gets overwritten.
    if (m_full && !out_ready && exp_q.size() > 0) void'(exp_q.pop_back());
    e.v = ev; e.c = ec; e.s = es;
    exp_q.push_back(e);
    tick(v, val, 1'b1);
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 10 && !done; i++) begin
      @(posedge clk);
      #1;
      if (!out_valid) done = 1'b1;
    end
    if (!done) check("drain_timeout", 32'd1, 32'd0);
    out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #2;
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_out_value", {24'b0, out_value}, 32'd0);
    check("rst_out_count", {26'b0, out_count}, 32'd0);
    check("rst_out_sat", {31'b0, out_sat}, 32'd0);
    check("rst_overrun", {31'b0, overrun}, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    reset_n = 1'b1;

    // +3 x4 then -2 on the dump cycle -> 10, count 5
    send(4, 4'h3);
    do_dump(1'b1, 4'hE, 8'd10, 6'd5, 1'b0);
    drain();

    // +7 x20 clamps at 127; next interval starts clean
    send(20, 4'h7);
    do_dump(1'b0, 4'h0, 8'h7F, 6'd20, 1'b1);
    drain();
    tick(1'b1, 4'h2, 1'b0);
    do_dump(1'b0, 4'h0, 8'd2, 6'd1, 1'b0);
    drain();

    // -8 x17 clamps at -128
    send(17, 4'h8);
    do_dump(1'b0, 4'h0, 8'h80, 6'd17, 1'b1);
    drain();

    // Empty interval is a normal zero result
    do_dump(1'b0, 4'h0, 8'd0, 6'd0, 1'b0);
    drain();

    // Counter saturates at 63
    send(70, 4'h0);
    do_dump(1'b0, 4'h0, 8'd0, 6'd63, 1'b0);
    drain();

    // Overwrite without ready: sums 5 then 9, overrun pulses
    tick(1'b1, 4'h5, 1'b0);
    do_dump(1'b0, 4'h0, 8'd5, 6'd1, 1'b0);
    send(1, 4'h4);
    send(1, 4'h5);
    do_dump(1'b0, 4'h0, 8'd9, 6'd2, 1'b0);
    tick(1'b0, 4'h0, 1'b0);
    drain();

    // Dump with ready while FULL: old result taken, new one loaded
    tick(1'b1, 4'h1, 1'b0);
    do_dump(1'b0, 4'h0, 8'd1, 6'd1, 1'b0);
    send(1, 4'h2);
    send(1, 4'h3);
    out_ready = 1'b1;
    do_dump(1'b1, 4'h4, 8'd9, 6'd3, 1'b0);
    drain();

    // Reset mid-interval with a result held: everything discarded
    tick(1'b1, 4'h4, 1'b0);
    do_dump(1'b0, 4'h0, 8'd4, 6'd1, 1'b0);
    send(2, 4'h4);
    #2;
    reset_n = 1'b0;
    #1;
    check("mid_rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("mid_rst_out_value", {24'b0, out_value}, 32'd0);
    check("mid_rst_out_count", {26'b0, out_count}, 32'd0);
    exp_q.delete();
    @(posedge clk); #1;
    reset_n = 1'b1;
    tick(1'b1, 4'h1, 1'b0);
    do_dump(1'b0, 4'h0, 8'd1, 6'd1, 1'b0);
    drain();

    repeat (3) @(posedge clk);
    #1;
    check("queue_empty", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/integrate_dump.md
INTEGRATE_DUMP -- requirements
Module: integrate_dump

Interface
REQ-001 Parameter IN_WIDTH, default 4: width of the signed two's-complement input sample, which is the sign-extended output of the sign-magnitude converter stage.
REQ-002 Parameter ACC_WIDTH, default 16: width of the signed accumulator and of the result; ACC_WIDTH > IN_WIDTH.
REQ-003 Parameter CNT_WIDTH, default 14: width of the sample counter.
REQ-004 Port clk, input, 1: the single clock; all state updates on the rising edge.
REQ-005 Port reset_n, input, 1: reset, asynchronous and active-low.
REQ-006 Port in_valid, input, 1: in_value carries a sample this cycle.
REQ-007 Port in_value, input, IN_WIDTH: signed two's-complement sample.
REQ-008 Port dump, input, 1: one-cycle strobe that ends the current integration interval.
REQ-009 Port out_ready, input, 1: the consumer accepts the result.
REQ-010 Port out_valid, output, 1: a result is held for the consumer.
REQ-011 Port out_value, output, ACC_WIDTH: signed integrated sum.
REQ-012 Port out_count, output, CNT_WIDTH: number of samples in the interval.
REQ-013 Port out_sat, output, 1: the interval saturated at least once.
REQ-014 Port overrun, output, 1: one-cycle pulse marking that an unconsumed result was overwritten.

Function
REQ-015 The block SHALL sign-extend in_value to ACC_WIDTH before every addition.
REQ-016 With in_valid=1 and dump=0, the accumulator SHALL become sat(acc + in_value).
- sat() clamps to +2^(ACC_WIDTH-1)-1 or -2^(ACC_WIDTH-1).
- Any clamp sets the sticky interval flag sat_flag.
REQ-017 With in_valid=1, the counter SHALL increment by one; at all-ones it SHALL hold (saturating) and wrap-around SHALL never occur.
REQ-018 With in_valid=0 and dump=0, the accumulator, counter and sat_flag SHALL hold.
REQ-019 On dump=1, the result registers SHALL load the interval totals on the same clock edge.
- The totals include the same-cycle sample when in_valid=1, with saturation and count rules applied.
- Registers loaded: out_value, out_count, out_sat.
REQ-020 On that same edge, the accumulator, counter and sat_flag SHALL clear to 0, so the next interval starts empty.
REQ-021 out_valid SHALL rise on the edge following the dump cycle, giving one cycle of latency from dump to result.
REQ-022 out_valid SHALL stay at 1 until a cycle with out_valid=1 and out_ready=1, and SHALL then fall on that edge unless REQ-024 applies.
REQ-023 While out_valid=1, out_value, out_count and out_sat SHALL stay stable until handshake or overwrite.
REQ-024 On dump with out_valid=1 and out_ready=1 in the same cycle, the new result SHALL load, out_valid SHALL stay at 1, and overrun SHALL stay at 0.
REQ-025 On dump with out_valid=1 and out_ready=0, the new result SHALL overwrite the held one, out_valid SHALL stay at 1, and overrun SHALL pulse to 1 for exactly one cycle after the edge.
REQ-026 A dump with no samples in the interval SHALL produce out_value=0, out_count=0 and out_sat=0 as a normal result.
REQ-027 out_ready SHALL be ignored while out_valid=0.
REQ-028 Output state machine:
- States: EMPTY (out_valid=0) and FULL (out_valid=1).
- EMPTY to FULL on dump.
- FULL to EMPTY on handshake without dump.
- FULL to FULL on dump, per REQ-024 and REQ-025.

Reset
REQ-029 While reset_n=0, the following SHALL be 0, asynchronously: accumulator, counter, sat_flag, out_valid, out_value, out_count, out_sat and overrun.
REQ-030 A reset asserted mid-interval SHALL discard the partial sum, and no result SHALL be produced for that interval.
REQ-031 After reset_n rises, the first rising clk edge SHALL process inputs normally.

Verification (IN_WIDTH=4, ACC_WIDTH=8, CNT_WIDTH=6)
REQ-032 Samples +3,+3,+3,+3,-2 with dump on the -2 cycle -> next cycle out_valid=1, out_value=10, out_count=5, out_sat=0.
REQ-033 Twenty samples of +7, then dump -> out_value=127 (0x7F), out_count=20, out_sat=1; the next interval starts at 0 with out_sat=0.
REQ-034 Seventeen samples of -8, then dump -> out_value=-128 (0x80), out_sat=1.
REQ-035 Two dumps with out_ready=0 (intervals of sum 5 and then 9) -> overrun pulses one cycle after the second dump, out_value=9, out_valid stays 1.
REQ-036 Dump with out_ready=1 while FULL -> out_valid stays 1, overrun=0, new result visible.
REQ-037 Reset pulse after +4,+4, then +1, dump -> out_value=1, out_count=1; no result is produced for the aborted interval.
